// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment/anode constants and scan state type for the display scanner
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex digit (entry 0 is rightmost)
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - data/strobe inputs and scan outputs of the display scanner
interface display_scan_ctrl_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output value, load, blank,
    input  seg, an, frame_tick
  );

  modport slave (
    input  value, load, blank,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex digit to active-low seven-segment decode
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[digit];

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit multiplexed seven-segment scanner with frame-synchronous update
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYC     = 1000
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] counter;
  scan_state_t   state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_flag;
  logic [3:0]    blank_q;
  logic          frame_tick_q;

  logic          slot_end;
  logic          frame_end;
  logic          lit;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;

  assign slot_end  = (counter == SLOT_LAST);
  assign frame_end = slot_end && (state == ST_ON) && (idx == 2'd3);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_GAP: if (counter == GAP_LAST) state_nxt = ST_ON;
      ST_ON: begin
        if (slot_end) begin
          state_nxt = ST_GAP;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: state_nxt = ST_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter      <= '0;
      state        <= ST_GAP;
      idx          <= 2'd0;
      active       <= 16'h0000;
      pending      <= 16'h0000;
      pend_flag    <= 1'b0;
      blank_q      <= 4'b0000;
      frame_tick_q <= 1'b0;
    end else begin
      counter      <= slot_end ? '0 : counter + CW'(1);
      state        <= state_nxt;
      idx          <= idx_nxt;
      blank_q      <= bus.blank;
      frame_tick_q <= frame_end;
      // Fresh data at the boundary wins over anything still pending
      if (frame_end && bus.load) begin
        active    <= bus.value;
        pend_flag <= 1'b0;
      end else if (frame_end && pend_flag) begin
        active    <= pending;
        pend_flag <= 1'b0;
      end else if (bus.load) begin
        pending   <= bus.value;
        pend_flag <= 1'b1;
      end
    end
  end

  assign digit = active[{idx, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .digit (digit),
    .seg   (digit_seg)
  );

  assign lit            = (state == ST_ON) && !blank_q[idx];
  assign bus.an         = lit ? ~(4'b0001 << idx) : AN_OFF;
  assign bus.seg        = lit ? digit_seg : SEG_OFF;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized, model-checked bench for display_scan_ctrl (REFRESH_DIV=8, GAP_CYC=2)
module tb_display_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  display_scan_ctrl_if bus();

  display_scan_ctrl #(.REFRESH_DIV(8), .GAP_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;

  logic [15:0] m_active;
  logic [15:0] m_pending;
  logic        m_pflag;
  logic [3:0]  m_blank;

  // Reference digit shapes written as lit-segment sets, then inverted for active-low
  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] on;
    case (d)
      4'h0: on = 7'b0111111;
      4'h1: on = 7'b0000110;
      4'h2: on = 7'b1011011;
      4'h3: on = 7'b1001111;
      4'h4: on = 7'b1100110;
      4'h5: on = 7'b1101101;
      4'h6: on = 7'b1111101;
      4'h7: on = 7'b0000111;
      4'h8: on = 7'b1111111;
      4'h9: on = 7'b1101111;
      4'hA: on = 7'b1110111;
      4'hB: on = 7'b1111100;
      4'hC: on = 7'b0111001;
      4'hD: on = 7'b1011110;
      4'hE: on = 7'b1111001;
      default: on = 7'b1110001;
    endcase
    return ~on;
  endfunction

  function automatic logic [3:0] exp_an();
    int slot = (t / 8) % 4;
    int pos  = t % 8;
    if (pos >= 2 && !m_blank[slot]) return ~(4'b0001 << slot);
    return 4'b1111;
  endfunction

  function automatic logic [6:0] exp_seg();
    int slot = (t / 8) % 4;
    int pos  = t % 8;
    if (pos >= 2 && !m_blank[slot]) return ref_seg(m_active[slot*4 +: 4]);
    return 7'b1111111;
  endfunction

  function automatic logic exp_tick();
    return (t > 0) && (t % 32 == 0);
  endfunction

  // One clock: model absorbs the inputs seen at the edge, then we return at the next falling edge
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_active = 16'h0000; m_pending = 16'h0000; m_pflag = 1'b0; m_blank = 4'b0000; t = 0;
    end else begin
      if (t % 32 == 31) begin
        if (bus.load) begin
          m_active = bus.value; m_pflag = 1'b0;
        end else if (m_pflag) begin
          m_active = m_pending; m_pflag = 1'b0;
        end
      end else if (bus.load) begin
        m_pending = bus.value; m_pflag = 1'b1;
      end
      m_blank = bus.blank;
      t++;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; bus.load = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.load = 1'b1; bus.value = 16'($urandom);
    step();
    step();
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", bus.seg); end
    checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", bus.frame_tick); end
    checks++; if (dut.pend_flag !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b exp=0", dut.pend_flag); end
    bus.load = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_scan_timing();
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      checks++; if (bus.an !== exp_an()) begin errors++; $display("FAIL scan_an t=%0d got=%b exp=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL scan_seg t=%0d got=%b exp=%b", t, bus.seg, exp_seg()); end
      checks++; if (bus.frame_tick !== exp_tick()) begin errors++; $display("FAIL scan_tick t=%0d got=%b exp=%b", t, bus.frame_tick, exp_tick()); end
      if (t == 2 || t == 7) begin
        checks++; if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000) begin errors++; $display("FAIL scan_digit0 t=%0d an=%b seg=%b exp an=1110 seg=1000000", t, bus.an, bus.seg); end
      end
      if (t == 28) begin
        checks++; if (bus.an !== 4'b0111) begin errors++; $display("FAIL scan_digit3 t=%0d got=%b exp=0111", t, bus.an); end
      end
      step();
    end
  endtask

  task automatic test_no_tearing();
    reset_dut();
    bus.value = 16'h4321;
    for (int i = 0; i < 50; i++) begin
      checks++; if (bus.an !== exp_an()) begin errors++; $display("FAIL tear_an t=%0d got=%b exp=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL tear_seg t=%0d got=%b exp=%b", t, bus.seg, exp_seg()); end
      checks++; if (bus.frame_tick !== exp_tick()) begin errors++; $display("FAIL tear_tick t=%0d got=%b exp=%b", t, bus.frame_tick, exp_tick()); end
      if (t == 31) begin
        checks++; if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL tear_old t=%0d got=%b exp=1000000", t, bus.seg); end
      end
      if (t == 34) begin
        checks++; if (bus.seg !== 7'b1111001) begin errors++; $display("FAIL tear_new0 t=%0d got=%b exp=1111001", t, bus.seg); end
      end
      if (t == 44) begin
        checks++; if (bus.seg !== 7'b0100100) begin errors++; $display("FAIL tear_new1 t=%0d got=%b exp=0100100", t, bus.seg); end
      end
      bus.load = (t == 5);
      step();
    end
    bus.load = 1'b0;
  endtask

  task automatic test_overwrite();
    reset_dut();
    for (int i = 0; i < 66; i++) begin
      checks++; if (bus.an !== exp_an()) begin errors++; $display("FAIL ovw_an t=%0d got=%b exp=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL ovw_seg t=%0d got=%b exp=%b", t, bus.seg, exp_seg()); end
      if (bus.an !== 4'b1111) begin
        checks++; if (bus.seg === 7'b1111001) begin errors++; $display("FAIL ovw_stale t=%0d got=%b exp=not 1111001", t, bus.seg); end
      end
      if (t == 34) begin
        checks++; if (bus.seg !== 7'b0100001) begin errors++; $display("FAIL ovw_d t=%0d got=%b exp=0100001", t, bus.seg); end
      end
      if (t == 58) begin
        checks++; if (bus.seg !== 7'b0001000) begin errors++; $display("FAIL ovw_a t=%0d got=%b exp=0001000", t, bus.seg); end
      end
      bus.load  = (t == 3) || (t == 20);
      bus.value = (t == 3) ? 16'h1111 : 16'hABCD;
      step();
    end
    bus.load = 1'b0;
  endtask

  task automatic test_simultaneous();
    reset_dut();
    for (int i = 0; i < 70; i++) begin
      checks++; if (bus.an !== exp_an()) begin errors++; $display("FAIL sim_an t=%0d got=%b exp=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL sim_seg t=%0d got=%b exp=%b", t, bus.seg, exp_seg()); end
      if (t == 32) begin
        checks++; if (dut.pend_flag !== 1'b0) begin errors++; $display("FAIL sim_pend t=%0d got=%b exp=0", t, dut.pend_flag); end
      end
      if (t == 34 || t == 66) begin
        checks++; if (bus.seg !== 7'b0100100) begin errors++; $display("FAIL sim_two t=%0d got=%b exp=0100100", t, bus.seg); end
      end
      bus.load  = (t == 10) || (t == 31);
      bus.value = (t == 10) ? 16'h1111 : 16'h2222;
      step();
    end
    bus.load = 1'b0;
  endtask

  task automatic test_blanking();
    reset_dut();
    bus.blank = 4'b0100;
    bus.value = 16'hBEEF;
    for (int i = 0; i < 40; i++) begin
      checks++; if (bus.an !== exp_an()) begin errors++; $display("FAIL blank_an t=%0d got=%b exp=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL blank_seg t=%0d got=%b exp=%b", t, bus.seg, exp_seg()); end
      if (t >= 18 && t <= 23) begin
        checks++; if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin errors++; $display("FAIL blank_dark t=%0d an=%b seg=%b exp an=1111 seg=1111111", t, bus.an, bus.seg); end
      end
      bus.load = (t == 1);
      step();
    end
    bus.load  = 1'b0;
    bus.blank = 4'b0000;
  endtask

  task automatic test_mid_frame_reset();
    reset_dut();
    bus.value = 16'h9876;
    while (t < 12) begin
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL mrst_pre t=%0d got=%b exp=%b", t, bus.seg, exp_seg()); end
      bus.load = (t == 5);
      step();
    end
    bus.load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin errors++; $display("FAIL mrst_out an=%b seg=%b exp an=1111 seg=1111111", bus.an, bus.seg); end
    checks++; if (dut.pend_flag !== 1'b0) begin errors++; $display("FAIL mrst_pend got=%b exp=0", dut.pend_flag); end
    for (int i = 0; i < 42; i++) begin
      checks++; if (bus.an !== exp_an()) begin errors++; $display("FAIL mrst_an t=%0d got=%b exp=%b", t, bus.an, exp_an()); end
      checks++; if (bus.frame_tick !== exp_tick()) begin errors++; $display("FAIL mrst_tick t=%0d got=%b exp=%b", t, bus.frame_tick, exp_tick()); end
      if (bus.an !== 4'b1111) begin
        checks++; if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL mrst_zero t=%0d got=%b exp=1000000", t, bus.seg); end
      end
      step();
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      checks++; if (bus.an !== exp_an()) begin errors++; $display("FAIL rand_an t=%0d got=%b exp=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL rand_seg t=%0d got=%b exp=%b", t, bus.seg, exp_seg()); end
      checks++; if (bus.frame_tick !== exp_tick()) begin errors++; $display("FAIL rand_tick t=%0d got=%b exp=%b", t, bus.frame_tick, exp_tick()); end
      bus.load  = ($urandom_range(0, 7) == 0) || ((t % 32 == 31) && ($urandom_range(0, 1) == 1));
      bus.value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.blank = 4'($urandom);
      step();
    end
    bus.load  = 1'b0;
    bus.blank = 4'b0000;
  endtask

  initial begin
    bus.value = 16'h0000;
    bus.load  = 1'b0;
    bus.blank = 4'b0000;
    m_active = 16'h0000; m_pending = 16'h0000; m_pflag = 1'b0; m_blank = 4'b0000;
    @(negedge clk);
    test_reset();
    test_scan_timing();
    test_no_tearing();
    test_overwrite();
    test_simultaneous();
    test_blanking();
    test_mid_frame_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
